// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Purpose  : Fetch-stage sequencer. Owns the fetch PC and runs the
//            instruction bus request/response handshake. Picks the next
//            fetch address (PC+4, EX branch/jump redirect, exception entry).
//            Squashes in-flight fetches on a redirect. Holds one
//            instruction for ID while ID stalls.
// Ports    : cpu_clk/cpu_rstn    - clock, synchronous active-low reset
//            br_taken/br_target  - EX-stage taken branch/jump redirect
//            excp_valid/excp_pc  - exception/ertn redirect (wins over branch)
//            id_stall            - ID cannot accept an instruction
//            inst_req/inst_addr  - bus request and address
//            inst_addr_ok        - bus accepted the address
//            inst_data_ok/rdata  - bus response
//            if_valid/if_pc/if_inst - instruction presented to ID
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  input  logic        id_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;     // where to resume once a squashed fetch drains
  logic        pend_valid;  // redirect seen while the address is not yet accepted
  logic        cancel;      // the outstanding fetch belongs to the old path

  logic        redir;
  logic [31:0] redir_pc;
  logic        consume;

  assign redir    = excp_valid | br_taken;
  assign redir_pc = excp_valid ? excp_pc : br_target;
  assign consume  = if_valid & ~id_stall;

  // The bus address is the fetch PC itself. While a redirect is pending in
  // REQ the fetch PC is left untouched, which keeps the address stable until
  // the bus accepts it.
  assign inst_addr = fetch_pc;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      pend_pc    <= RESET_PC;
      pend_valid <= 1'b0;
      cancel     <= 1'b0;
      inst_req   <= 1'b0;
      if_valid   <= 1'b0;
      if_pc      <= 32'h0;
      if_inst    <= 32'h0;
    end else begin
      // ID took the presented instruction this cycle.
      if (consume) begin
        if_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          inst_req <= 1'b1;
          if (redir) begin
            fetch_pc <= redir_pc;
          end
        end

        S_REQ: begin
          if (inst_addr_ok) begin
            state      <= S_WAIT;
            inst_req   <= 1'b0;
            pend_valid <= 1'b0;
            if (redir) begin
              cancel  <= 1'b1;
              pend_pc <= redir_pc;
            end else begin
              cancel  <= pend_valid;
            end
          end else if (redir) begin
            // Address cannot be withdrawn; remember where to go afterwards.
            pend_pc    <= redir_pc;
            pend_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (inst_data_ok) begin
            cancel   <= 1'b0;
            state    <= S_REQ;
            inst_req <= 1'b1;
            if (redir) begin
              fetch_pc <= redir_pc;
            end else if (cancel) begin
              fetch_pc <= pend_pc;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= fetch_pc;
              if_inst  <= inst_rdata;
              fetch_pc <= fetch_pc + 32'd4;
              if (id_stall) begin
                state    <= S_HOLD;
                inst_req <= 1'b0;
              end
            end
          end else if (redir) begin
            cancel  <= 1'b1;
            pend_pc <= redir_pc;
          end
        end

        S_HOLD: begin
          if (redir) begin
            fetch_pc <= redir_pc;
            state    <= S_REQ;
            inst_req <= 1'b1;
          end else if (!id_stall) begin
            state    <= S_REQ;
            inst_req <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          inst_req <= 1'b0;
        end
      endcase

      // A redirect flushes whatever is presented, stall or not.
      if (redir) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_ctrl
// Purpose  : Self-checking bench for fetch_pc_ctrl. A transaction-level
//            model of the fetch stream and a simple bus slave drive and
//            predict the DUT; literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        br_taken, excp_valid, id_stall;
  logic [31:0] br_target, excp_pc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;

  fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rstn    (cpu_rstn),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .excp_valid  (excp_valid),
    .excp_pc     (excp_pc),
    .id_stall    (id_stall),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst)
  );

  always #5 cpu_clk = ~cpu_clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
  endfunction

  // ---------------- transaction-level model ----------------
  bit          m_boot, m_req, m_disc, m_out, m_keep, m_hold, m_vld;
  logic [31:0] m_next, m_req_addr, m_out_pc, m_pc, m_inst;

  task automatic m_open(input logic [31:0] a);
    m_req = 1; m_req_addr = a; m_disc = 0;
  endtask

  task automatic model_step(input bit rstn, input bit stall, input bit br, input logic [31:0] bt,
                            input bit ex, input logic [31:0] ep, input bit aok, input bit dok,
                            input logic [31:0] rd);
    bit redir, consumed, got;
    logic [31:0] rpc;
    if (!rstn) begin
      m_boot = 1; m_req = 0; m_disc = 0; m_out = 0; m_keep = 0; m_hold = 0; m_vld = 0;
      m_next = RST_PC; m_req_addr = RST_PC; m_out_pc = 0; m_pc = 0; m_inst = 0;
      return;
    end
    redir    = br | ex;
    rpc      = ex ? ep : bt;
    consumed = m_vld & ~stall;
    got      = 0;
    if (m_boot) begin
      m_boot = 0;
      if (redir) m_next = rpc;
      m_open(m_next);
    end else if (m_req) begin
      if (redir) begin m_next = rpc; m_disc = 1; end
      if (aok) begin
        m_req = 0; m_out = 1; m_keep = !m_disc; m_out_pc = m_req_addr;
      end
    end else if (m_out) begin
      if (dok) begin
        m_out = 0;
        if (m_keep && !redir) begin
          got = 1; m_pc = m_out_pc; m_inst = rd; m_next = m_out_pc + 32'd4;
          if (stall) m_hold = 1; else m_open(m_next);
        end else begin
          if (redir) m_next = rpc;
          m_open(m_next);
        end
      end else if (redir) begin
        m_next = rpc; m_keep = 0;
      end
    end else if (m_hold) begin
      if (redir) begin m_next = rpc; m_hold = 0; m_open(m_next); end
      else if (!stall) begin m_hold = 0; m_open(m_next); end
    end
    if (redir)         m_vld = 0;
    else if (got)      m_vld = 1;
    else if (consumed) m_vld = 0;
  endtask

  // ---------------- compare process ----------------
  always @(negedge cpu_clk) begin
    if (cmp_en) begin
      chk("model_if_valid", 32'(if_valid), 32'(m_vld));
      chk("model_if_pc",    if_pc,   m_pc);
      chk("model_if_inst",  if_inst, m_inst);
      chk("model_inst_req", 32'(inst_req), 32'(m_req));
      if (m_req) chk("model_inst_addr", inst_addr, m_req_addr);
    end
  end

  // ---------------- bus slave + one-cycle driver ----------------
  bit          bus_busy = 0;
  int          bus_cnt  = 0;
  int          bus_dly  = 1;
  logic [31:0] bus_addr = 0;

  task automatic cyc(input bit stall, input bit br, input logic [31:0] bt,
                     input bit ex, input logic [31:0] ep, input bit aok_en);
    bit dok, aok, req_s;
    logic [31:0] rd, addr_s;
    dok    = bus_busy && (bus_cnt == 0);
    aok    = aok_en && !bus_busy;
    rd     = dok ? rdf(bus_addr) : $urandom;
    id_stall = stall; br_taken = br; br_target = bt; excp_valid = ex; excp_pc = ep;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    req_s  = inst_req;
    addr_s = inst_addr;
    @(posedge cpu_clk);
    model_step(cpu_rstn, stall, br, bt, ex, ep, aok, dok, rd);
    if (dok) bus_busy = 0;
    else if (bus_busy && bus_cnt > 0) bus_cnt--;
    if (aok && req_s) begin
      bus_busy = 1; bus_addr = addr_s; bus_cnt = bus_dly - 1;
    end
    @(negedge cpu_clk);
  endtask

  task automatic nc();
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    cpu_rstn = 0;
    for (int i = 0; i < 8 && (i == 0 || bus_busy); i++) nc();
    chk("rst_inst_req",  32'(inst_req), 0);
    chk("rst_inst_addr", inst_addr, RST_PC);
    chk("rst_if_valid",  32'(if_valid), 0);
    chk("rst_if_pc",     if_pc, 0);
    chk("rst_if_inst",   if_inst, 0);
    cpu_rstn = 1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if (r[3:0] == 4'd0) return r[4] ? 32'hffff_fffc : 32'hffff_fff8;
    return RST_PC | (r & 32'h0000_fffc);
  endfunction

  initial begin
    cpu_rstn = 0; br_taken = 0; br_target = 0; excp_valid = 0; excp_pc = 0;
    id_stall = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    nc();
    cmp_en = 1;

    // Sequential stream, then a 5-cycle stall on 1c000004.
    bus_dly = 1;
    do_reset();
    nc(); chk("a_first_req", 32'(inst_req), 1); chk("a_first_addr", inst_addr, 32'h1c00_0000);
    nc(); chk("a_wait_noreq", 32'(inst_req), 0);
    nc(); chk("a_v0", 32'(if_valid), 1); chk("a_pc0", if_pc, 32'h1c00_0000);
    chk("a_inst0", if_inst, rdf(32'h1c00_0000));
    nc(); chk("a_gap", 32'(if_valid), 0);
    cyc(1, 0, 0, 0, 0, 1);
    chk("a_v1", 32'(if_valid), 1); chk("a_pc1", if_pc, 32'h1c00_0004);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 1);
      chk("a_hold_v", 32'(if_valid), 1); chk("a_hold_pc", if_pc, 32'h1c00_0004);
      chk("a_hold_noreq", 32'(inst_req), 0);
    end
    nc(); chk("a_rel_req", 32'(inst_req), 1); chk("a_rel_addr", inst_addr, 32'h1c00_0008);
    chk("a_rel_v", 32'(if_valid), 0);
    nc(); nc(); chk("a_v2", 32'(if_valid), 1); chk("a_pc2", if_pc, 32'h1c00_0008);

    // Branch during WAIT, response three cycles after acceptance is dropped.
    bus_dly = 3;
    do_reset();
    nc(); nc();
    cyc(0, 1, 32'h1c00_0100, 0, 0, 1);
    chk("b_v_e3", 32'(if_valid), 0); chk("b_req_e3", 32'(inst_req), 0);
    nc(); chk("b_req_e4", 32'(inst_req), 0);
    bus_dly = 1;
    nc(); chk("b_drop_v", 32'(if_valid), 0); chk("b_req", 32'(inst_req), 1);
    chk("b_addr", inst_addr, 32'h1c00_0100);
    nc(); nc(); chk("b_v", 32'(if_valid), 1); chk("b_pc", if_pc, 32'h1c00_0100);
    chk("b_inst", if_inst, rdf(32'h1c00_0100));

    // Branch and exception together: exception wins.
    do_reset();
    nc();
    cyc(0, 1, 32'h1c00_0200, 1, 32'h1c00_1000, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        nc(); chk("c_req", 32'(inst_req), 1); chk("c_addr", inst_addr, 32'h1c00_1000);
      end else nc();
      chk("c_no_br_path", 32'(if_valid && if_pc == 32'h1c00_0200), 0);
    end
    chk("c_pc", if_pc, 32'h1c00_1000);

    // Redirect while the address waits four cycles for acceptance.
    do_reset();
    nc();
    cyc(0, 1, 32'h1c00_0300, 0, 0, 0);
    chk("d_addr_hold", inst_addr, 32'h1c00_0000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("d_req_hold", 32'(inst_req), 1); chk("d_addr_hold", inst_addr, 32'h1c00_0000);
    end
    nc(); chk("d_accepted", 32'(inst_req), 0);
    nc(); chk("d_drop_v", 32'(if_valid), 0); chk("d_new_addr", inst_addr, 32'h1c00_0300);
    nc(); nc(); chk("d_pc", if_pc, 32'h1c00_0300);

    // Sequential wrap at the top of the address space.
    do_reset();
    nc();
    cyc(0, 0, 0, 1, 32'hffff_fffc, 1);
    nc(); chk("e_addr", inst_addr, 32'hffff_fffc);
    nc(); nc();
    chk("e_pc", if_pc, 32'hffff_fffc); chk("e_wrap_req", 32'(inst_req), 1);
    chk("e_wrap_addr", inst_addr, 32'h0000_0000);

    // Reset in the middle of WAIT; the stale response is ignored.
    bus_dly = 1;
    do_reset();
    nc(); nc(); nc();
    bus_dly = 3;
    nc();
    cpu_rstn = 0;
    nc();
    chk("f_inst_req", 32'(inst_req), 0); chk("f_addr", inst_addr, RST_PC);
    chk("f_v", 32'(if_valid), 0); chk("f_pc", if_pc, 0); chk("f_inst", if_inst, 0);
    cpu_rstn = 1;
    nc(); chk("f_req", 32'(inst_req), 1); chk("f_req_addr", inst_addr, RST_PC);
    nc(); chk("f_stale_v", 32'(if_valid), 0); chk("f_stale_req", 32'(inst_req), 1);
    bus_dly = 1;
    nc(); nc();
    chk("f_refetch_v", 32'(if_valid), 1); chk("f_refetch_pc", if_pc, RST_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus_dly  = $urandom_range(1, 4);
      cpu_rstn = ($urandom % 300) != 0;
      cyc(($urandom % 100) < 30, ($urandom % 100) < 6, rand_pc(),
          ($urandom % 100) < 2, rand_pc(), ($urandom % 100) < 70);
    end
    cpu_rstn = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
